ball_engine: RTL and testbench
==============================

Name: ball_engine

Overview:
- Parametrised ball-motion engine for the Pong playfield. Generalised successor to the single-step ball mover.
- Adds per-axis bounce on collision strobes, configurable playfield bounds and widths, multi-pixel step speed that rises with paddle hits, a serve/launch state machine, and out-of-bounds scoring pulses.
- Sits between the collision detectors and the VGA renderer.
- Advances only on the frame-rate update strobe.

Parameters:
X_W, 10, ballX width
Y_W, 9, ballY width
X_MIN, 0, leftmost legal ballX
X_MAX, 639, rightmost legal ballX
Y_MIN, 0, top legal ballY
Y_MAX, 479, bottom legal ballY
START_X, 320, serve/recentre X
START_Y, 240, serve/recentre Y
SPD_W, 3, speed register width
MAX_SPEED, 6, speed ceiling in pixels per tick (1..2^SPD_W-1)
HITS_PER_LEVEL, 4, paddle hits per speed increment
SERVE_DELAY, 60, ticks between serve and motion

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
tick  in  1  update strobe, one cycle per frame, asserted with collision-detector clear
col_x1  in  1  collision on left side of ball
col_x2  in  1  collision on right side of ball
col_y1  in  1  collision on top side
col_y2  in  1  collision on bottom side
paddle_hit  in  1  current X collision is with a paddle; qualified by tick
serve  in  1  launch request, single-cycle pulse
serve_dir  in  1  0 = launch rightward, 1 = launch leftward
ballX  out  X_W  ball X position
ballY  out  Y_W  ball Y position
dir_x  out  1  0 = +X, 1 = -X
dir_y  out  1  0 = +Y, 1 = -Y
speed  out  SPD_W  current step size
score_left  out  1  one-cycle pulse: ball exited past X_MAX (left player scores)
score_right  out  1  one-cycle pulse: ball exited past X_MIN
in_play  out  1  high only in PLAY

Behaviour:
- Reset (rst low, async):
  - state=HOLD; ballX=START_X; ballY=START_Y.
  - dir_x=0, dir_y=0; speed=1; hit_cnt=0; serve_cnt=0.
  - Score pulses 0; in_play 0.
- All state is registered; nothing changes on a non-tick cycle except the serve accept and clearing of the score pulses.

State machine:
- HOLD:
  - Position forced to START.
  - serve=1 -> SERVE_WAIT on next edge: dir_x=serve_dir, dir_y=0, speed=1, hit_cnt=0, serve_cnt=SERVE_DELAY.
  - tick is ignored.
- SERVE_WAIT:
  - Each tick decrements serve_cnt.
  - A tick seen with serve_cnt==0 -> PLAY, with no movement on that tick.
  - SERVE_DELAY=0 gives PLAY on the first tick.
  - serve is ignored.
- PLAY, on tick:
  - X direction:
    - col_x1&col_x2: no X move, dir_x unchanged.
    - else col_x2: dir_x=1.
    - else col_x1: dir_x=0.
  - Y direction: same rules using col_y1/col_y2.
  - Movement uses the updated direction (bounce takes effect on the same tick). Step = speed.
  - Arithmetic is done signed at X_W+2 / Y_W+2 bits.
  - Y result < Y_MIN: clamp to Y_MIN, force dir_y=0. Y result > Y_MAX: clamp to Y_MAX, force dir_y=1.
  - X result < X_MIN: ballX=X_MIN, score_right=1 for one cycle, -> OUT.
  - X result > X_MAX: ballX=X_MAX, score_left=1 for one cycle, -> OUT.
  - paddle_hit with col_x1|col_x2: hit_cnt+1. When it reaches HITS_PER_LEVEL, hit_cnt=0 and speed=min(speed+1, MAX_SPEED).
  - paddle_hit without an X collision is ignored.
- OUT: the next tick -> HOLD, with ballX/ballY recentred on that transition.
- Score pulses are never simultaneous and are never asserted outside the PLAY->OUT transition.
- Reset mid-PLAY or mid-SERVE_WAIT returns all outputs immediately to their reset values.

Decomposition:
- pong_pkg:
  - state encoding (HOLD, SERVE_WAIT, PLAY, OUT);
  - direction constants DIR_POS=0 and DIR_NEG=1;
  - playfield defaults (640x480 bounds, centre).
- One natural sub-module, ball_axis. It is instantiated twice (X, Y) and owns position, direction, collision-bounce, clamp and the out-of-range flag for one axis, parametrised by width and bounds. The top level holds the FSM, speed and hit counter.

Test Plan:
- Reset, then serve=1 with serve_dir=0, SERVE_DELAY=2 -> in_play rises on the 3rd tick; next tick gives ballX=321, ballY=241.
- PLAY at ballX=400, dir_x=0, tick with col_x2=1 -> dir_x=1, ballX=399 on the same update.
- col_x1=col_x2=1 on a tick at ballX=200 -> ballX stays 200, dir_x unchanged; Y still moves.
- ballY=478, dir_y=0, speed=3 -> ballY clamps to 479, dir_y=1.
- 8 ticks with paddle_hit&col_x1 (HITS_PER_LEVEL=4) -> speed 1->3. Further hits beyond MAX_SPEED leave speed=6.
- ballX=1, dir_x=1, speed=2, tick -> score_right high for exactly one cycle, ballX=0, state OUT. Next tick gives HOLD with ballX=320, ballY=240.
- Assert rst low mid-PLAY -> outputs at reset values without waiting for a clk edge.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants for the Pong ball engine: FSM encoding, direction codes
// and default playfield geometry.
package pong_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_HOLD       = 2'd0;
    localparam state_t ST_SERVE_WAIT = 2'd1;
    localparam state_t ST_PLAY       = 2'd2;
    localparam state_t ST_OUT        = 2'd3;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    localparam int PF_X_MIN   = 0;
    localparam int PF_X_MAX   = 639;
    localparam int PF_Y_MIN   = 0;
    localparam int PF_Y_MAX   = 479;
    localparam int PF_START_X = 320;
    localparam int PF_START_Y = 240;

    // Bits needed to hold the values 0..max_val (never less than one).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ball_engine_if.sv
// Bundle between the collision/control side and the ball engine; the engine
// uses the slave view, the driver (game logic or bench) the master view.
interface ball_engine_if #(
    parameter int X_W   = 10,
    parameter int Y_W   = 9,
    parameter int SPD_W = 3
);
    logic             tick;
    logic             col_x1;
    logic             col_x2;
    logic             col_y1;
    logic             col_y2;
    logic             paddle_hit;
    logic             serve;
    logic             serve_dir;
    logic [X_W-1:0]   ballX;
    logic [Y_W-1:0]   ballY;
    logic             dir_x;
    logic             dir_y;
    logic [SPD_W-1:0] speed;
    logic             score_left;
    logic             score_right;
    logic             in_play;

    modport master (
        output tick, col_x1, col_x2, col_y1, col_y2, paddle_hit, serve, serve_dir,
        input  ballX, ballY, dir_x, dir_y, speed, score_left, score_right, in_play
    );

    modport slave (
        input  tick, col_x1, col_x2, col_y1, col_y2, paddle_hit, serve, serve_dir,
        output ballX, ballY, dir_x, dir_y, speed, score_left, score_right, in_play
    );
endinterface

// File: rtl/ball_axis.sv
// One axis of ball motion: position, direction, collision bounce, clamping
// to [MIN, MAX] and the out-of-range flags for the pending move.
module ball_axis
    import pong_pkg::*;
#(
    parameter int   W           = 10,
    parameter int   SPD_W       = 3,
    parameter int   MIN         = 0,
    parameter int   MAX         = 639,
    parameter int   START       = 320,
    parameter logic EDGE_BOUNCE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_move,
    input  logic             i_recentre,
    input  logic             i_load_dir,
    input  logic             i_dir_val,
    input  logic             i_col_lo,
    input  logic             i_col_hi,
    input  logic [SPD_W-1:0] i_step,
    output logic [W-1:0]     o_pos,
    output logic             o_dir,
    output logic             o_under,
    output logic             o_over
);

    localparam logic signed [W+1:0] MIN_S   = (W+2)'(MIN);
    localparam logic signed [W+1:0] MAX_S   = (W+2)'(MAX);
    localparam logic        [W-1:0] MIN_U   = W'(MIN);
    localparam logic        [W-1:0] MAX_U   = W'(MAX);
    localparam logic        [W-1:0] START_U = W'(START);

    logic [W-1:0]          r_pos;
    logic                  r_dir;
    logic                  w_hold;
    logic                  w_dir_next;
    logic                  w_dir_move;
    logic signed [W+1:0]   w_pos_s;
    logic signed [W+1:0]   w_step_s;
    logic signed [W+1:0]   w_sum;
    logic [W-1:0]          w_pos_next;

    // Hits on both sides pin the ball on this axis; otherwise the struck side
    // reflects it, and the new direction applies to this very step.
    always_comb begin
        w_hold     = i_col_lo & i_col_hi;
        w_dir_next = r_dir;
        if (!w_hold && i_col_hi)
            w_dir_next = DIR_NEG;
        else if (!w_hold && i_col_lo)
            w_dir_next = DIR_POS;

        w_pos_s  = signed'({2'b00, r_pos});
        w_step_s = signed'({{(W+2-SPD_W){1'b0}}, i_step});
        if (w_hold)
            w_sum = w_pos_s;
        else if (w_dir_next == DIR_NEG)
            w_sum = w_pos_s - w_step_s;
        else
            w_sum = w_pos_s + w_step_s;

        o_under = (w_sum < MIN_S);
        o_over  = (w_sum > MAX_S);

        w_pos_next = w_sum[W-1:0];
        if (o_under)
            w_pos_next = MIN_U;
        else if (o_over)
            w_pos_next = MAX_U;

        w_dir_move = w_dir_next;
        if (EDGE_BOUNCE && o_under)
            w_dir_move = DIR_POS;
        else if (EDGE_BOUNCE && o_over)
            w_dir_move = DIR_NEG;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pos <= START_U;
            r_dir <= DIR_POS;
        end else if (i_move) begin
            r_pos <= w_pos_next;
            r_dir <= w_dir_move;
        end else begin
            if (i_recentre)
                r_pos <= START_U;
            if (i_load_dir)
                r_dir <= i_dir_val;
        end
    end

    assign o_pos = r_pos;
    assign o_dir = r_dir;

endmodule

// File: rtl/ball_engine.sv
// Pong ball engine: serve/play/score FSM, speed ramp on paddle hits, and two
// ball_axis instances doing the per-axis motion on each frame tick.
module ball_engine
    import pong_pkg::*;
#(
    parameter int X_W            = 10,
    parameter int Y_W            = 9,
    parameter int X_MIN          = PF_X_MIN,
    parameter int X_MAX          = PF_X_MAX,
    parameter int Y_MIN          = PF_Y_MIN,
    parameter int Y_MAX          = PF_Y_MAX,
    parameter int START_X        = PF_START_X,
    parameter int START_Y        = PF_START_Y,
    parameter int SPD_W          = 3,
    parameter int MAX_SPEED      = 6,
    parameter int HITS_PER_LEVEL = 4,
    parameter int SERVE_DELAY    = 60
) (
    input  logic clk,
    input  logic rst,
    ball_engine_if.slave bus
);

    localparam int HIT_W = cnt_width(HITS_PER_LEVEL);
    localparam int SRV_W = cnt_width(SERVE_DELAY);

    state_t           r_state;
    logic [SPD_W-1:0] r_speed;
    logic [HIT_W-1:0] r_hit_cnt;
    logic [SRV_W-1:0] r_serve_cnt;
    logic             r_score_left;
    logic             r_score_right;

    logic w_move, w_recentre, w_serve_acc, w_paddle_count;
    logic w_x_under, w_x_over, w_y_under, w_y_over;

    assign w_move         = bus.tick && (r_state == ST_PLAY);
    assign w_recentre     = (r_state == ST_HOLD) || (bus.tick && (r_state == ST_OUT));
    assign w_serve_acc    = (r_state == ST_HOLD) && bus.serve;
    assign w_paddle_count = w_move && bus.paddle_hit && (bus.col_x1 || bus.col_x2);

    ball_axis #(
        .W(X_W), .SPD_W(SPD_W), .MIN(X_MIN), .MAX(X_MAX), .START(START_X), .EDGE_BOUNCE(1'b0)
    ) u_axis_x (
        .clk(clk), .rst(rst), .i_move(w_move), .i_recentre(w_recentre),
        .i_load_dir(w_serve_acc), .i_dir_val(bus.serve_dir),
        .i_col_lo(bus.col_x1), .i_col_hi(bus.col_x2), .i_step(r_speed),
        .o_pos(bus.ballX), .o_dir(bus.dir_x), .o_under(w_x_under), .o_over(w_x_over)
    );

    ball_axis #(
        .W(Y_W), .SPD_W(SPD_W), .MIN(Y_MIN), .MAX(Y_MAX), .START(START_Y), .EDGE_BOUNCE(1'b1)
    ) u_axis_y (
        .clk(clk), .rst(rst), .i_move(w_move), .i_recentre(w_recentre),
        .i_load_dir(w_serve_acc), .i_dir_val(DIR_POS),
        .i_col_lo(bus.col_y1), .i_col_hi(bus.col_y2), .i_step(r_speed),
        .o_pos(bus.ballY), .o_dir(bus.dir_y), .o_under(w_y_under), .o_over(w_y_over)
    );

    // A single step can never overshoot both bounds of an axis at once.
    always_comb begin
        if (rst && w_move)
            assert (!(w_x_under && w_x_over) && !(w_y_under && w_y_over));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_HOLD;
            r_speed       <= SPD_W'(1);
            r_hit_cnt     <= '0;
            r_serve_cnt   <= '0;
            r_score_left  <= 1'b0;
            r_score_right <= 1'b0;
        end else begin
            r_score_left  <= 1'b0;
            r_score_right <= 1'b0;
            case (r_state)
                ST_HOLD: begin
                    if (bus.serve) begin
                        r_state     <= ST_SERVE_WAIT;
                        r_speed     <= SPD_W'(1);
                        r_hit_cnt   <= '0;
                        r_serve_cnt <= SRV_W'(SERVE_DELAY);
                    end
                end
                ST_SERVE_WAIT: begin
                    if (bus.tick) begin
                        if (r_serve_cnt == '0)
                            r_state <= ST_PLAY;
                        else
                            r_serve_cnt <= r_serve_cnt - 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (bus.tick) begin
                        if (w_x_under) begin
                            r_score_right <= 1'b1;
                            r_state       <= ST_OUT;
                        end else if (w_x_over) begin
                            r_score_left <= 1'b1;
                            r_state      <= ST_OUT;
                        end
                    end
                    // Speed ramps one pixel per level of paddle hits, saturating.
                    if (w_paddle_count) begin
                        if (r_hit_cnt == HIT_W'(HITS_PER_LEVEL - 1)) begin
                            r_hit_cnt <= '0;
                            if (r_speed < SPD_W'(MAX_SPEED))
                                r_speed <= r_speed + 1'b1;
                        end else begin
                            r_hit_cnt <= r_hit_cnt + 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (bus.tick)
                        r_state <= ST_HOLD;
                end
                default: r_state <= ST_HOLD;
            endcase
        end
    end

    assign bus.speed       = r_speed;
    assign bus.score_left  = r_score_left;
    assign bus.score_right = r_score_right;
    assign bus.in_play     = (r_state == ST_PLAY);

endmodule

// File: tb/tb_ball_engine.sv
// Directed scenarios for ball_engine (SERVE_DELAY=2): serve, bounces, clamp,
// speed ramp and ceiling, both scoring exits and asynchronous reset.
module tb_ball_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ball_engine_if #(.X_W(10), .Y_W(9), .SPD_W(3)) bus ();

    ball_engine #(.SERVE_DELAY(2)) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    task automatic do_tick(input logic x1, input logic x2, input logic y1, input logic y2, input logic ph);
        @(negedge clk);
        bus.col_x1 = x1; bus.col_x2 = x2; bus.col_y1 = y1; bus.col_y2 = y2;
        bus.paddle_hit = ph; bus.tick = 1'b1;
        @(posedge clk);
        #1;
        bus.tick = 1'b0; bus.col_x1 = 1'b0; bus.col_x2 = 1'b0;
        bus.col_y1 = 1'b0; bus.col_y2 = 1'b0; bus.paddle_hit = 1'b0;
    endtask

    task automatic do_serve(input logic d);
        @(negedge clk);
        bus.serve = 1'b1; bus.serve_dir = d;
        @(posedge clk);
        #1;
        bus.serve = 1'b0;
    endtask

    task automatic test_reset();
        bus.tick = 0; bus.col_x1 = 0; bus.col_x2 = 0; bus.col_y1 = 0; bus.col_y2 = 0;
        bus.paddle_hit = 0; bus.serve = 0; bus.serve_dir = 0;
        #23;
        n_checks++; if (bus.ballX !== 10'd320) begin n_errors++; $display("FAIL reset_x got %0d want 320", bus.ballX); end
        n_checks++; if (bus.ballY !== 9'd240) begin n_errors++; $display("FAIL reset_y got %0d want 240", bus.ballY); end
        n_checks++; if ({bus.dir_x, bus.dir_y, bus.in_play, bus.score_left, bus.score_right} !== 5'b0) begin
            n_errors++; $display("FAIL reset_flags got %b want 00000", {bus.dir_x, bus.dir_y, bus.in_play, bus.score_left, bus.score_right}); end
        n_checks++; if (bus.speed !== 3'd1) begin n_errors++; $display("FAIL reset_speed got %0d want 1", bus.speed); end
        @(negedge clk); rst_n = 1'b1;
        do_tick(0, 0, 0, 0, 0);
        n_checks++; if (bus.in_play !== 1'b0 || bus.ballX !== 10'd320) begin
            n_errors++; $display("FAIL hold_ignores_tick got in_play=%b x=%0d want 0/320", bus.in_play, bus.ballX); end
        $display("test_reset: x=%0d y=%0d speed=%0d", bus.ballX, bus.ballY, bus.speed);
    endtask

    task automatic test_serve();
        do_serve(1'b0);
        do_tick(0, 0, 0, 0, 0);
        do_tick(0, 0, 0, 0, 0);
        n_checks++; if (bus.in_play !== 1'b0) begin n_errors++; $display("FAIL serve_wait2 got in_play=%b want 0", bus.in_play); end
        do_tick(0, 0, 0, 0, 0);
        n_checks++; if (bus.in_play !== 1'b1 || bus.ballX !== 10'd320) begin
            n_errors++; $display("FAIL serve_launch got in_play=%b x=%0d want 1/320", bus.in_play, bus.ballX); end
        do_tick(0, 0, 0, 0, 0);
        n_checks++; if (bus.ballX !== 10'd321 || bus.ballY !== 9'd241) begin
            n_errors++; $display("FAIL serve_first_move got %0d,%0d want 321,241", bus.ballX, bus.ballY); end
        $display("test_serve: x=%0d y=%0d in_play=%b", bus.ballX, bus.ballY, bus.in_play);
    endtask

    task automatic test_bounce();
        repeat (79) do_tick(0, 0, 0, 0, 0);
        n_checks++; if (bus.ballX !== 10'd400 || bus.ballY !== 9'd320) begin
            n_errors++; $display("FAIL pre_bounce got %0d,%0d want 400,320", bus.ballX, bus.ballY); end
        do_tick(0, 1, 0, 0, 0);
        n_checks++; if (bus.dir_x !== 1'b1 || bus.ballX !== 10'd399 || bus.ballY !== 9'd321) begin
            n_errors++; $display("FAIL bounce_x2 got dir=%b x=%0d y=%0d want 1/399/321", bus.dir_x, bus.ballX, bus.ballY); end
        $display("test_bounce: x=%0d dir_x=%b", bus.ballX, bus.dir_x);
    endtask

    task automatic test_both_cols();
        repeat (199) do_tick(0, 0, 0, 0, 0);
        n_checks++; if (bus.ballX !== 10'd200 || bus.ballY !== 9'd439 || bus.dir_y !== 1'b1) begin
            n_errors++; $display("FAIL pre_both got x=%0d y=%0d dy=%b want 200/439/1", bus.ballX, bus.ballY, bus.dir_y); end
        do_tick(1, 1, 0, 0, 0);
        n_checks++; if (bus.ballX !== 10'd200 || bus.dir_x !== 1'b1 || bus.ballY !== 9'd438) begin
            n_errors++; $display("FAIL both_x got x=%0d dx=%b y=%0d want 200/1/438", bus.ballX, bus.dir_x, bus.ballY); end
        $display("test_both_cols: x=%0d y=%0d", bus.ballX, bus.ballY);
    endtask

    task automatic test_speed();
        repeat (4) do_tick(1, 0, 1, 1, 1);
        n_checks++; if (bus.speed !== 3'd2 || bus.ballX !== 10'd204 || bus.ballY !== 9'd438 || bus.dir_x !== 1'b0) begin
            n_errors++; $display("FAIL speed_lvl1 got spd=%0d x=%0d y=%0d dx=%b want 2/204/438/0", bus.speed, bus.ballX, bus.ballY, bus.dir_x); end
        repeat (4) do_tick(1, 0, 0, 0, 1);
        n_checks++; if (bus.speed !== 3'd3 || bus.ballX !== 10'd212 || bus.ballY !== 9'd430) begin
            n_errors++; $display("FAIL speed_lvl2 got spd=%0d x=%0d y=%0d want 3/212/430", bus.speed, bus.ballX, bus.ballY); end
        $display("test_speed: speed=%0d x=%0d", bus.speed, bus.ballX);
    endtask

    task automatic test_y_clamp();
        do_tick(0, 0, 1, 0, 1);
        n_checks++; if (bus.ballY !== 9'd433 || bus.dir_y !== 1'b0 || bus.ballX !== 10'd215) begin
            n_errors++; $display("FAIL y1_bounce got y=%0d dy=%b x=%0d want 433/0/215", bus.ballY, bus.dir_y, bus.ballX); end
        repeat (15) do_tick(0, 0, 0, 0, 0);
        n_checks++; if (bus.ballY !== 9'd478 || bus.ballX !== 10'd260) begin
            n_errors++; $display("FAIL pre_clamp got y=%0d x=%0d want 478/260", bus.ballY, bus.ballX); end
        do_tick(0, 0, 0, 0, 0);
        n_checks++; if (bus.ballY !== 9'd479 || bus.dir_y !== 1'b1 || bus.ballX !== 10'd263) begin
            n_errors++; $display("FAIL y_clamp got y=%0d dy=%b x=%0d want 479/1/263", bus.ballY, bus.dir_y, bus.ballX); end
        $display("test_y_clamp: y=%0d dir_y=%b", bus.ballY, bus.dir_y);
    endtask

    task automatic test_max_speed();
        repeat (16) do_tick(1, 0, 1, 1, 1);
        n_checks++; if (bus.speed !== 3'd6 || bus.ballX !== 10'd335 || bus.ballY !== 9'd479) begin
            n_errors++; $display("FAIL max_speed got spd=%0d x=%0d y=%0d want 6/335/479", bus.speed, bus.ballX, bus.ballY); end
        $display("test_max_speed: speed=%0d x=%0d", bus.speed, bus.ballX);
    endtask

    task automatic test_score_right();
        do_tick(0, 1, 1, 1, 0);
        repeat (54) do_tick(0, 0, 1, 1, 0);
        n_checks++; if (bus.ballX !== 10'd5 || bus.score_right !== 1'b0 || bus.in_play !== 1'b1) begin
            n_errors++; $display("FAIL pre_exit_left got x=%0d sr=%b ip=%b want 5/0/1", bus.ballX, bus.score_right, bus.in_play); end
        do_tick(0, 0, 1, 1, 0);
        n_checks++; if (bus.score_right !== 1'b1 || bus.score_left !== 1'b0 || bus.ballX !== 10'd0 || bus.in_play !== 1'b0) begin
            n_errors++; $display("FAIL exit_left got sr=%b sl=%b x=%0d ip=%b want 1/0/0/0", bus.score_right, bus.score_left, bus.ballX, bus.in_play); end
        @(posedge clk); #1;
        n_checks++; if (bus.score_right !== 1'b0) begin n_errors++; $display("FAIL score_right_pulse got %b want 0", bus.score_right); end
        do_tick(0, 0, 0, 0, 0);
        n_checks++; if (bus.ballX !== 10'd320 || bus.ballY !== 9'd240 || bus.in_play !== 1'b0) begin
            n_errors++; $display("FAIL out_to_hold got %0d,%0d ip=%b want 320,240/0", bus.ballX, bus.ballY, bus.in_play); end
        $display("test_score_right: x=%0d y=%0d", bus.ballX, bus.ballY);
    endtask

    task automatic test_score_left();
        do_serve(1'b0);
        n_checks++; if (bus.speed !== 3'd1 || bus.dir_x !== 1'b0 || bus.dir_y !== 1'b0) begin
            n_errors++; $display("FAIL serve_init got spd=%0d dx=%b dy=%b want 1/0/0", bus.speed, bus.dir_x, bus.dir_y); end
        do_tick(0, 0, 0, 0, 0);
        do_serve(1'b1);
        n_checks++; if (bus.dir_x !== 1'b0) begin n_errors++; $display("FAIL serve_ignored got dx=%b want 0", bus.dir_x); end
        do_tick(0, 0, 0, 0, 0);
        do_tick(0, 0, 0, 0, 0);
        n_checks++; if (bus.in_play !== 1'b1) begin n_errors++; $display("FAIL serve2_launch got ip=%b want 1", bus.in_play); end
        repeat (319) do_tick(0, 0, 1, 1, 0);
        n_checks++; if (bus.ballX !== 10'd639 || bus.score_left !== 1'b0) begin
            n_errors++; $display("FAIL at_x_max got x=%0d sl=%b want 639/0", bus.ballX, bus.score_left); end
        do_tick(0, 0, 1, 1, 0);
        n_checks++; if (bus.score_left !== 1'b1 || bus.score_right !== 1'b0 || bus.ballX !== 10'd639 || bus.in_play !== 1'b0) begin
            n_errors++; $display("FAIL exit_right got sl=%b sr=%b x=%0d ip=%b want 1/0/639/0", bus.score_left, bus.score_right, bus.ballX, bus.in_play); end
        do_tick(0, 0, 0, 0, 0);
        n_checks++; if (bus.score_left !== 1'b0 || bus.ballX !== 10'd320) begin
            n_errors++; $display("FAIL left_recentre got sl=%b x=%0d want 0/320", bus.score_left, bus.ballX); end
        $display("test_score_left: x=%0d", bus.ballX);
    endtask

    task automatic test_async_reset();
        do_serve(1'b1);
        repeat (5) do_tick(0, 0, 0, 0, 0);
        n_checks++; if (bus.ballX !== 10'd318 || bus.ballY !== 9'd242 || bus.dir_x !== 1'b1) begin
            n_errors++; $display("FAIL pre_reset got x=%0d y=%0d dx=%b want 318/242/1", bus.ballX, bus.ballY, bus.dir_x); end
        @(negedge clk); #2; rst_n = 1'b0; #1;
        n_checks++; if (bus.ballX !== 10'd320 || bus.ballY !== 9'd240 || bus.dir_x !== 1'b0 || bus.in_play !== 1'b0 || bus.speed !== 3'd1) begin
            n_errors++; $display("FAIL async_reset got x=%0d y=%0d dx=%b ip=%b spd=%0d want 320/240/0/0/1", bus.ballX, bus.ballY, bus.dir_x, bus.in_play, bus.speed); end
        @(negedge clk); rst_n = 1'b1;
        $display("test_async_reset: x=%0d y=%0d", bus.ballX, bus.ballY);
    endtask

    initial begin
        test_reset();
        test_serve();
        test_bounce();
        test_both_cols();
        test_speed();
        test_y_clamp();
        test_max_speed();
        test_score_right();
        test_score_left();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
